// File: rtl/config_usb_upload.sv
// rtl/config_usb_upload.sv - DFU upload streamer: 4-byte header, then configuration words MSB first
module config_usb_upload #(
  parameter int         WORD_COUNT   = 'd512,
  parameter logic [7:0] COMMAND      = 8'h01,
  parameter int         READ_TIMEOUT = 'd255,
  localparam int        AW           = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          dfu_mode_i,
  input  logic [2:0]    dfu_alt_i,
  input  logic          dfu_in_en_i,
  input  logic          dfu_clear_status_i,
  output logic [7:0]    dfu_in_data_o,
  output logic          dfu_in_valid_o,
  input  logic          dfu_in_ready_i,
  output logic [3:0]    dfu_status_o,
  output logic          word_read_strobe_o,
  output logic [AW-1:0] word_addr_o,
  input  logic [31:0]   read_data_i,
  input  logic          read_valid_i
);

  typedef enum logic [3:0] {
    IDLE, HDR_00, HDR_AA, HDR_FF, HDR_CMD, REQ_WORD, WAIT_WORD, SEND_BYTE, DONE, ERR
  } state_t;

  localparam logic [AW-1:0] LAST_WORD = AW'(WORD_COUNT - 1);
  localparam logic [31:0]   TMO_LIMIT = 32'(READ_TIMEOUT);

  // Leaving DFU mode or alternate setting 2 wipes the block immediately.
  logic rst_local_n;
  assign rst_local_n = reset_n_i & dfu_mode_i & (dfu_alt_i == 3'd2);

  state_t        state_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          strobe_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] word_cnt_q;
  logic [1:0]    byte_idx_q;
  logic [31:0]   shift_q;
  logic [31:0]   tmo_q;
  logic [3:0]    status_q;
  logic          hs;

  assign hs = valid_q & dfu_in_ready_i;

  always_ff @(posedge clk_i or negedge rst_local_n) begin
    if (!rst_local_n) begin
      state_q    <= IDLE;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'h0;
      tmo_q      <= 32'h0;
      status_q   <= 4'h0;
    end else if (dfu_clear_status_i) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      tmo_q      <= 32'h0;
      status_q   <= 4'h0;
    end else if (!dfu_in_en_i && !(state_q inside {IDLE, DONE, ERR})) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      tmo_q      <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (dfu_in_en_i) begin
            data_q  <= 8'h00;
            valid_q <= 1'b1;
            state_q <= HDR_00;
          end
        end
        HDR_00: if (hs) begin data_q <= 8'hAA;   state_q <= HDR_AA;  end
        HDR_AA: if (hs) begin data_q <= 8'hFF;   state_q <= HDR_FF;  end
        HDR_FF: if (hs) begin data_q <= COMMAND; state_q <= HDR_CMD; end
        HDR_CMD: begin
          // The strobe is raised on the way in so it is visible throughout REQ_WORD.
          if (hs) begin
            valid_q  <= 1'b0;
            strobe_q <= 1'b1;
            addr_q   <= word_cnt_q;
            state_q  <= REQ_WORD;
          end
        end
        REQ_WORD: begin
          strobe_q <= 1'b0;
          tmo_q    <= 32'h0;
          state_q  <= WAIT_WORD;
        end
        WAIT_WORD: begin
          if (read_valid_i) begin
            shift_q    <= read_data_i;
            data_q     <= read_data_i[31:24];
            valid_q    <= 1'b1;
            byte_idx_q <= 2'd0;
            state_q    <= SEND_BYTE;
          end else if (tmo_q + 32'd1 >= TMO_LIMIT) begin
            status_q <= 4'h1;
            state_q  <= ERR;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        SEND_BYTE: begin
          if (hs) begin
            if (byte_idx_q == 2'd3) begin
              valid_q    <= 1'b0;
              word_cnt_q <= word_cnt_q + AW'(1);
              if (word_cnt_q == LAST_WORD) begin
                state_q <= DONE;
              end else begin
                strobe_q <= 1'b1;
                addr_q   <= word_cnt_q + AW'(1);
                state_q  <= REQ_WORD;
              end
            end else begin
              shift_q    <= shift_q << 8;
              data_q     <= shift_q[23:16];
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          if (!dfu_in_en_i) state_q <= IDLE;
        end
        ERR: begin
          valid_q  <= 1'b0;
          status_q <= 4'h1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dfu_in_data_o      = data_q;
  assign dfu_in_valid_o     = valid_q;
  assign dfu_status_o       = status_q;
  assign word_read_strobe_o = strobe_q;
  assign word_addr_o        = addr_q;

endmodule

// File: tb/tb_config_usb_upload.sv
// tb/tb_config_usb_upload.sv - vector table plus byte/address scoreboard bench for config_usb_upload
module tb_config_usb_upload;

  localparam int         WC  = 2;
  localparam int         TMO = 8;
  localparam logic [7:0] CMD = 8'h01;

  logic        clk_i = 1'b0;
  logic        reset_n_i, dfu_mode_i, dfu_in_en_i, dfu_clear_status_i, dfu_in_ready_i, read_valid_i;
  logic [2:0]  dfu_alt_i;
  logic [31:0] read_data_i;
  logic [7:0]  dfu_in_data_o;
  logic        dfu_in_valid_o, word_read_strobe_o;
  logic [3:0]  dfu_status_o;
  logic [0:0]  word_addr_o;

  always #5 clk_i = ~clk_i;

  config_usb_upload #(.WORD_COUNT(WC), .COMMAND(CMD), .READ_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .dfu_mode_i(dfu_mode_i), .dfu_alt_i(dfu_alt_i),
    .dfu_in_en_i(dfu_in_en_i), .dfu_clear_status_i(dfu_clear_status_i),
    .dfu_in_data_o(dfu_in_data_o), .dfu_in_valid_o(dfu_in_valid_o), .dfu_in_ready_i(dfu_in_ready_i),
    .dfu_status_o(dfu_status_o), .word_read_strobe_o(word_read_strobe_o), .word_addr_o(word_addr_o),
    .read_data_i(read_data_i), .read_valid_i(read_valid_i)
  );

  typedef struct {
    logic rst, mode; logic [2:0] alt; logic en, rdy, clr; int n;
    logic ev; logic [7:0] ed; logic es; logic [3:0] est;
  } vec_t;
  vec_t vt[14];

  int n_pass = 0, n_total = 0;
  logic [7:0]  exp_q[$];
  int          exp_addr_q[$];
  logic [7:0]  rx[$];
  logic [31:0] mem[WC];
  bit resp_on, pending, ready_toggle, prev_v, prev_r;
  logic [7:0] prev_d;
  int resp_lat, resp_cnt, pend_addr, cyc, first_strobe_cyc, last_byte_cyc, strobe_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic fail(input string name, input int act);
    n_total++;
    $display("FAIL %s: got %0d required none", name, act);
  endtask

  // One clock: sample at negedge, consume/compare, then drive responder and ready after posedge.
  task automatic cycle();
    logic [7:0] e;
    int a;
    @(negedge clk_i);
    if (prev_v && !prev_r && dfu_in_valid_o) check("hold_data", dfu_in_data_o, prev_d);
    prev_v = dfu_in_valid_o; prev_r = dfu_in_ready_i; prev_d = dfu_in_data_o;
    if (dfu_in_valid_o && dfu_in_ready_i) begin
      rx.push_back(dfu_in_data_o);
      last_byte_cyc = cyc;
      if (exp_q.size() == 0) fail("extra_byte", dfu_in_data_o);
      else begin e = exp_q.pop_front(); check("byte", dfu_in_data_o, e); end
    end
    if (word_read_strobe_o) begin
      if (strobe_count == 0) first_strobe_cyc = cyc;
      strobe_count++;
      if (exp_addr_q.size() == 0) fail("extra_strobe", word_addr_o);
      else begin
        a = exp_addr_q.pop_front();
        check("strobe_addr", word_addr_o, a);
        pending = 1; pend_addr = a; resp_cnt = resp_lat;
      end
    end
    @(posedge clk_i); #1;
    read_valid_i = 1'b0;
    if (pending && resp_on) begin
      if (resp_cnt <= 1) begin
        read_valid_i = 1'b1;
        read_data_i  = mem[pend_addr];
        exp_q.push_back(mem[pend_addr][31:24]); exp_q.push_back(mem[pend_addr][23:16]);
        exp_q.push_back(mem[pend_addr][15:8]);  exp_q.push_back(mem[pend_addr][7:0]);
        pending = 0;
      end else resp_cnt--;
    end
    if (ready_toggle) dfu_in_ready_i = ~dfu_in_ready_i;
    cyc++;
  endtask

  task automatic start_upload(input int n_words);
    prev_v = 0; prev_r = 0; pending = 0; cyc = 0; strobe_count = 0; rx.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'hAA); exp_q.push_back(8'hFF); exp_q.push_back(CMD);
    for (int i = 0; i < n_words; i++) exp_addr_q.push_back(i);
    dfu_in_en_i = 1'b1;
  endtask

  task automatic run_upload(input int bound, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0 || pending) && n < bound) begin
      cycle(); n++;
    end
    if (n >= bound) fail(name, exp_q.size());
    repeat (6) cycle();
  endtask

  // Download-side model: strip the header and reassemble words MSB first.
  task automatic loopback_check(input string name);
    logic [31:0] hdr, w;
    if (rx.size() != 4 + 4 * WC) begin fail({name, "_len"}, rx.size()); return; end
    hdr = {rx[0], rx[1], rx[2], rx[3]};
    check({name, "_hdr"}, hdr, {8'h00, 8'hAA, 8'hFF, CMD});
    for (int i = 0; i < WC; i++) begin
      w = {rx[4+4*i], rx[5+4*i], rx[6+4*i], rx[7+4*i]};
      check({name, "_word"}, w, mem[i]);
    end
  endtask

  task automatic go_idle();
    dfu_in_en_i = 0; dfu_clear_status_i = 0; read_valid_i = 0; dfu_in_ready_i = 1;
    reset_n_i = 1; dfu_mode_i = 1; dfu_alt_i = 3'd2; ready_toggle = 0;
    exp_q.delete(); exp_addr_q.delete(); pending = 0;
    repeat (3) begin @(posedge clk_i); end
    #1;
  endtask

  initial begin
    reset_n_i = 0; dfu_mode_i = 1; dfu_alt_i = 3'd2; dfu_in_en_i = 0; dfu_clear_status_i = 0;
    dfu_in_ready_i = 0; read_valid_i = 0; read_data_i = 32'h0;
    resp_on = 0; resp_lat = 1; ready_toggle = 0;
    //          rst   mode  alt   en    rdy   clr   n   ev    ed     es    est
    vt[0]  = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3,  1'b0, 8'h00, 1'b0, 4'h0};
    vt[1]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1,  1'b1, 8'h00, 1'b0, 4'h0};
    vt[2]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 4,  1'b1, 8'h00, 1'b0, 4'h0};
    vt[3]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 2,  1'b1, 8'hAA, 1'b0, 4'h0};
    vt[4]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 3,  1'b1, 8'hFF, 1'b0, 4'h0};
    vt[5]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 4,  1'b1, CMD,   1'b0, 4'h0};
    vt[6]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 5,  1'b0, CMD,   1'b1, 4'h0};
    vt[7]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 6,  1'b0, CMD,   1'b0, 4'h0};
    vt[8]  = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 3,  1'b0, 8'h00, 1'b0, 4'h0};
    vt[9]  = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3,  1'b0, 8'h00, 1'b0, 4'h0};
    vt[10] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 3,  1'b0, 8'h00, 1'b0, 4'h0};
    vt[11] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 13, 1'b0, CMD,   1'b0, 4'h0};
    vt[12] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 14, 1'b0, CMD,   1'b0, 4'h1};
    vt[13] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 3,  1'b0, 8'h00, 1'b0, 4'h0};

    for (int i = 0; i < 14; i++) begin
      reset_n_i = 0; dfu_in_en_i = 0; dfu_clear_status_i = 0;
      @(posedge clk_i); #1;
      reset_n_i = vt[i].rst; dfu_mode_i = vt[i].mode; dfu_alt_i = vt[i].alt;
      dfu_in_en_i = vt[i].en; dfu_in_ready_i = vt[i].rdy; dfu_clear_status_i = vt[i].clr;
      repeat (vt[i].n) begin @(posedge clk_i); end
      #1;
      check($sformatf("vec%0d_valid", i),  dfu_in_valid_o,     vt[i].ev);
      check($sformatf("vec%0d_data", i),   dfu_in_data_o,      vt[i].ed);
      check($sformatf("vec%0d_strobe", i), word_read_strobe_o, vt[i].es);
      check($sformatf("vec%0d_status", i), dfu_status_o,       vt[i].est);
    end

    // Normal upload, ready high, responder latency 1.
    go_idle();
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h01234567;
    resp_on = 1; resp_lat = 1;
    start_upload(WC);
    run_upload(100, "normal_bound");
    check("normal_first_strobe_cyc", first_strobe_cyc, 5);
    check("normal_last_byte_cyc", last_byte_cyc, 16);
    check("normal_strobe_count", strobe_count, WC);
    check("normal_done_valid", dfu_in_valid_o, 1'b0);
    loopback_check("normal_loop");

    // Backpressure with ready toggling every cycle, responder latency 2.
    go_idle();
    mem[0] = 32'hA5C30F96; mem[1] = 32'h7E0180FF;
    resp_lat = 2; ready_toggle = 1;
    start_upload(WC);
    run_upload(200, "bp_bound");
    check("bp_done_valid", dfu_in_valid_o, 1'b0);
    loopback_check("bp_loop");

    // Read timeout: nobody answers the strobe.
    go_idle();
    resp_on = 0;
    start_upload(1);
    begin
      bit seen = 0;
      while (cyc < 40 && !seen) begin
        cycle();
        if (strobe_count > 0 && cyc == first_strobe_cyc + 8) check("tmo_status_before", dfu_status_o, 4'h0);
        if (strobe_count > 0 && cyc == first_strobe_cyc + 9) begin
          check("tmo_status_err", dfu_status_o, 4'h1);
          check("tmo_valid_low", dfu_in_valid_o, 1'b0);
          seen = 1;
        end
      end
      if (!seen) fail("tmo_never_reached", cyc);
    end
    dfu_in_en_i = 0; dfu_clear_status_i = 1;
    cycle();
    dfu_clear_status_i = 0;
    check("tmo_clear_status", dfu_status_o, 4'h0);
    pending = 0;
    cycle();
    check("tmo_clear_idle_valid", dfu_in_valid_o, 1'b0);

    // Abort after byte 6, then restart from the header at address 0.
    go_idle();
    mem[0] = 32'h11223344; mem[1] = 32'h55667788;
    resp_on = 1; resp_lat = 1;
    start_upload(WC);
    while (rx.size() < 6 && cyc < 60) cycle();
    if (rx.size() < 6) fail("abort_reach6", rx.size());
    dfu_in_en_i = 0; dfu_in_ready_i = 0;
    cycle();
    check("abort_valid_low", dfu_in_valid_o, 1'b0);
    exp_q.delete(); exp_addr_q.delete(); pending = 0;
    dfu_in_ready_i = 1;
    start_upload(WC);
    run_upload(100, "restart_bound");
    loopback_check("restart_loop");

    // Alternate setting leaves 2 mid-word: asynchronous clear, no strobes while away.
    go_idle();
    start_upload(WC);
    while (rx.size() < 5 && cyc < 60) cycle();
    if (rx.size() < 5) fail("alt_reach5", rx.size());
    #2; dfu_alt_i = 3'd0; #1;
    check("alt_valid", dfu_in_valid_o, 1'b0);
    check("alt_data", dfu_in_data_o, 8'h00);
    check("alt_strobe", word_read_strobe_o, 1'b0);
    check("alt_addr", word_addr_o, 1'b0);
    check("alt_status", dfu_status_o, 4'h0);
    exp_q.delete(); exp_addr_q.delete(); pending = 0; strobe_count = 0;
    repeat (10) cycle();
    check("alt_no_strobes", strobe_count, 0);
    check("alt_still_idle", dfu_in_valid_o, 1'b0);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/config_usb_upload.md
# config_usb_upload

Upload-direction counterpart of the DFU configuration download path. While USB_DFU is in DFU mode on alternate setting 2 and in dfuUPLOAD_IDLE, the block emits the 4-byte header (00 AA FF, command), then reads `WORD_COUNT` 32-bit configuration words one at a time from a word-read port and streams each MSB first as bytes on the DFU IN handshake. Its stream is byte-compatible with what the download path accepts. It sits between USB_DFU's `dfu_in_*` interface and the fabric configuration readback logic.

## Interface

- `WORD_COUNT`, default `'d512`: number of words uploaded per session; must be ≥ 1.
- `COMMAND`, default `8'h01`: command byte sent as the 4th header byte.
- `READ_TIMEOUT`, default `'d255`: maximum cycles from a read strobe to `read_valid_i`.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `reset_n_i` in 1: reset, asynchronous and active-low.
- `dfu_mode_i` in 1: high while USB_DFU is in DFU mode.
- `dfu_alt_i` in 3: current alternate setting; the block is active only at 3'd2.
- `dfu_in_en_i` in 1: high while DFU is in dfuUPLOAD_IDLE.
- `dfu_clear_status_i` in 1: high while DFU is in dfuIDLE.
- `dfu_in_data_o` out 8: upload byte.
- `dfu_in_valid_o` out 1: `dfu_in_data_o` is valid.
- `dfu_in_ready_i` in 1: the byte is consumed when valid and ready are both high at a clock edge.
- `dfu_status_o` out 4: 4'h0 means OK; 4'h1 means errTARGET.
- `word_read_strobe_o` out 1: one-cycle read request.
- `word_addr_o` out `$clog2(WORD_COUNT)`: word index of the current request.
- `read_data_i` in 32: read data; valid only in the cycle `read_valid_i` is high.
- `read_valid_i` in 1: read response, arriving ≥1 cycle after the strobe.

## Operation

- **Local reset:** `reset_n_local = reset_n_i & dfu_mode_i & (dfu_alt_i == 3'd2)`. It asynchronously clears all state.
- **Reset values:**
  - `dfu_in_data_o` = 8'h00
  - `dfu_in_valid_o` = 0
  - `word_read_strobe_o` = 0
  - `word_addr_o` = 0
  - `dfu_status_o` = 4'h0
  - FSM in IDLE; word counter 0; byte index 0.
- **FSM states:** IDLE, HDR_00, HDR_AA, HDR_FF, HDR_CMD, REQ_WORD, WAIT_WORD, SEND_BYTE, DONE, ERR.
- **IDLE:** valid low. If `dfu_in_en_i` is high, load 8'h00, assert valid, and go to HDR_00.
- **HDR_00 → HDR_AA → HDR_FF → HDR_CMD:** each state advances only on a handshake (valid & ready). On that edge, load the next byte (8'hAA, 8'hFF, `COMMAND`) with valid still high.
- **HDR_CMD:** on handshake, drop valid and go to REQ_WORD.
- **REQ_WORD:** pulse `word_read_strobe_o` for exactly 1 cycle with `word_addr_o` = word counter, then go to WAIT_WORD.
- **WAIT_WORD:**
  - Runs a timeout counter from 0.
  - On `read_valid_i`, capture `read_data_i` into a 32-bit shift register, present bits [31:24] with valid high, set byte index 0, and go to SEND_BYTE.
  - If the counter reaches `READ_TIMEOUT` without `read_valid_i`, go to ERR.
- **SEND_BYTE:** on each handshake, shift left by 8 and increment the byte index.
  - After the handshake with byte index 3, drop valid and increment the word counter.
  - If the counter was `WORD_COUNT`-1, go to DONE; otherwise go to REQ_WORD.
- **DONE:** valid low and no further strobes. USB_DFU sees no data and terminates the upload with a short packet. The block returns to IDLE when `dfu_in_en_i` is low.
- **ERR:** `dfu_status_o` = 4'h1 and valid low. Leave only when `dfu_clear_status_i` is high; then go to IDLE, status 4'h0, counters 0.
- **Abort:** if `dfu_in_en_i` goes low in any state other than IDLE, DONE, or ERR, go to IDLE next cycle with valid low and the word counter cleared. A late `read_valid_i` in IDLE is ignored.
- **Clear status:** `dfu_clear_status_i` high in any state forces IDLE. It has priority over abort and over handshakes.
- **Data stability:** `dfu_in_data_o` stays stable while valid is high and ready is low. After valid falls it holds its last value.

## Timing

- All outputs are registered.
- First header byte is valid 1 cycle after `dfu_in_en_i` is sampled high in IDLE.
- With ready held high, the header takes 4 consecutive cycles.
- Handshake on the last header or word byte in cycle t:
  - strobe at t+1
  - `read_valid_i` at t+1+L (L ≥ 1)
  - first data byte valid at t+2+L
- Byte rate within a word is 1 per cycle while ready is high.
- `word_addr_o` is updated in the cycle after the increment and holds until the next strobe.
- Timeout compare is ≥ `READ_TIMEOUT` counted from the cycle after the strobe.

## Test plan

- **Normal upload:** `WORD_COUNT`=2, ready always high, responder L=1 returning 32'hDEADBEEF then 32'h01234567. Bytes must be 00 AA FF 01 DE AD BE EF 01 23 45 67; strobes at addr 0 then 1; then DONE with valid low.
- **Backpressure:** ready toggling every other cycle. The byte sequence is identical and data holds while ready is low.
- **Read timeout:** responder never answers, `READ_TIMEOUT`=8. `dfu_status_o` becomes 4'h1 at 9 cycles after the strobe with valid low. A `dfu_clear_status_i` pulse returns it to 4'h0 and IDLE.
- **Abort:** `dfu_in_en_i` dropped after byte 6. Next cycle valid=0 and the FSM is in IDLE. Re-enable restarts at 00 AA FF with addr 0.
- **Alternate setting change:** `dfu_alt_i` switched to 3'd0 mid-word. All outputs take their reset values asynchronously, and no strobe occurs while the alternate setting is not 2.
- **Loopback:** upload output looped into the download path. The words written there equal the words read.
